// File: rtl/miniRV_pkg.sv
// Shared miniRV definitions: major-opcode constants, encoding formats
// and the opcode-to-format classifier.
package miniRV_pkg;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_OPIMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_OPIMM32  = 5'b00110;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_OP32     = 5'b01110;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILLEGAL
    } instr_format_t;

    function automatic instr_format_t fmt_of(input logic [6:0] op);
        instr_format_t f;
        case (op[6:2])
            OP_OP, OP_OP32:        f = FMT_R;
            OP_OPIMM, OP_LOAD,
            OP_JALR, OP_SYSTEM,
            OP_OPIMM32:            f = FMT_I;
            OP_STORE:              f = FMT_S;
            OP_BRANCH:             f = FMT_B;
            OP_LUI, OP_AUIPC:      f = FMT_U;
            OP_JAL:                f = FMT_J;
            default:               f = FMT_ILLEGAL;
        endcase
        if (op[1:0] != 2'b11) f = FMT_ILLEGAL;
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the
// instruction encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immediate_32bit;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        err_illegal;
    logic [7:0]  illegal_count;

    modport master (
        output in_valid, opcode, rd, rs1, rs2,
        output funct3, funct7, immediate_32bit,
        output out_ready,
        input  in_ready, out_valid, out_word,
        input  out_addr, err_illegal, illegal_count
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2,
        input  funct3, funct7, immediate_32bit,
        input  out_ready,
        output in_ready, out_valid, out_word,
        output out_addr, err_illegal, illegal_count
    );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with occupancy counter; push/pop are ignored when
// full/empty respectively.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// Packs RISC-V field bundles into 32-bit instruction words and queues
// them with a running byte address; illegal opcodes are dropped.
module instr_encoder
    import miniRV_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    instr_encoder_if.slave bus
);
    instr_format_t fmt;
    logic [31:0]   imm;
    logic [31:0]   enc_word;
    logic [31:0]   head_word;
    logic          full, empty;
    logic          accept, legal, push, pop;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;

    assign fmt    = fmt_of(bus.opcode);
    assign imm    = bus.immediate_32bit;
    assign legal  = (fmt != FMT_ILLEGAL);
    assign accept = bus.in_valid && !full;
    assign push   = accept && legal;
    assign pop    = !empty && bus.out_ready;

    always_comb begin
        enc_word = '0;
        unique case (fmt)
            FMT_R: enc_word = {bus.funct7, bus.rs2, bus.rs1,
                               bus.funct3, bus.rd, bus.opcode};
            FMT_I: enc_word = {imm[11:0], bus.rs1,
                               bus.funct3, bus.rd, bus.opcode};
            FMT_S: enc_word = {imm[11:5], bus.rs2, bus.rs1,
                               bus.funct3, imm[4:0], bus.opcode};
            FMT_B: enc_word = {imm[12], imm[10:5], bus.rs2,
                               bus.rs1, bus.funct3, imm[4:1],
                               imm[11], bus.opcode};
            FMT_U: enc_word = {imm[31:12], bus.rd, bus.opcode};
            FMT_J: enc_word = {imm[20], imm[10:1], imm[11],
                               imm[19:12], bus.rd, bus.opcode};
            default: enc_word = '0;
        endcase
    end

    always_comb begin
        addr_d = pop ? addr_q + 32'd4 : addr_q;
        err_d  = accept && !legal;
        cnt_d  = cnt_q;
        if (err_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (head_word),
        .full  (full),
        .empty (empty)
    );

    // Empty head reads as zero so the idle output is deterministic.
    assign bus.in_ready      = !full;
    assign bus.out_valid     = !empty;
    assign bus.out_word      = empty ? '0 : head_word;
    assign bus.out_addr      = addr_q;
    assign bus.err_illegal   = err_q;
    assign bus.illegal_count = cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, backpressure
// and reset sequences, then random traffic against a queue model.
module tb_instr_encoder;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    instr_encoder_if bus ();

    instr_encoder #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t tab [8];
    logic [31:0] q [$];
    logic [6:0]  legal_ops [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.opcode          = v.op;
        bus.rd              = v.rd;
        bus.rs1             = v.rs1;
        bus.rs2             = v.rs2;
        bus.funct3          = v.f3;
        bus.funct7          = v.f7;
        bus.immediate_32bit = v.imm;
        bus.in_valid        = 1'b1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference encoder built from the field placement rules with
    // shifts and masks on plain 32-bit values.
    function automatic void model_enc(input vec_t v, output bit legal,
                                      output logic [31:0] w);
        logic [31:0] o, d, a, b, f, s, i;
        o = 32'(v.op);
        d = 32'(v.rd) << 7;
        f = 32'(v.f3) << 12;
        a = 32'(v.rs1) << 15;
        b = 32'(v.rs2) << 20;
        s = 32'(v.f7) << 25;
        i = v.imm;
        legal = 1'b1;
        case (v.op)
            7'h33, 7'h3B:
                w = o | d | f | a | b | s;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h1B:
                w = o | d | f | a | ((i & 32'hFFF) << 20);
            7'h23:
                w = o | ((i & 32'h1F) << 7) | f | a | b
                  | (((i >> 5) & 32'h7F) << 25);
            7'h63:
                w = o | f | a | b
                  | (((i >> 1) & 32'hF) << 8)
                  | (((i >> 11) & 32'h1) << 7)
                  | (((i >> 5) & 32'h3F) << 25)
                  | (((i >> 12) & 32'h1) << 31);
            7'h37, 7'h17:
                w = o | d | (i & 32'hFFFFF000);
            7'h6F:
                w = o | d | (i & 32'h000FF000)
                  | (((i >> 11) & 32'h1) << 20)
                  | (((i >> 1) & 32'h3FF) << 21)
                  | (((i >> 20) & 32'h1) << 31);
            default: begin
                w = '0;
                legal = 1'b0;
            end
        endcase
    endfunction

    initial begin
        logic [31:0] ea;
        logic [31:0] m_addr;
        logic [7:0]  m_cnt;
        bit          m_err;
        vec_t        v;
        vec_t        ill;
        bit          lg;
        logic [31:0] w;
        bit          acc, pp;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.in_valid        = 1'b0;
        bus.out_ready       = 1'b0;
        bus.opcode          = '0;
        bus.rd              = '0;
        bus.rs1             = '0;
        bus.rs2             = '0;
        bus.funct3          = '0;
        bus.funct7          = '0;
        bus.immediate_32bit = '0;

        tab[0] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'd5, 32'h00500093};
        tab[1] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,
                   32'd0, 32'h002081B3};
        tab[2] = '{7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'd0,
                   32'd8, 32'h0020A423};
        tab[3] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
                   32'd8, 32'h00208463};
        tab[4] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'h12345000, 32'h123452B7};
        tab[5] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'd16, 32'h010000EF};
        tab[6] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'hFFFFFFFC, 32'hFFDFF06F};
        tab[7] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'hFFFFFFFC, 32'hFE000EE3};

        legal_ops = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h73,
                      7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

        do_reset();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_word", bus.out_word, 32'd0);
        chk("rst_out_addr", bus.out_addr, 32'd0);
        chk("rst_count", 32'(bus.illegal_count), 32'd0);
        chk("rst_err", 32'(bus.err_illegal), 32'd0);

        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("tab_idle", 32'(bus.out_valid), 32'd0);
            drive(tab[k]);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("tab_valid", 32'(bus.out_valid), 32'd1);
            chk($sformatf("tab_word%0d", k), bus.out_word, tab[k].exp);
            chk($sformatf("tab_addr%0d", k), bus.out_addr,
                32'(4 * k));
            @(negedge clk);
        end

        do_reset();
        ill = tab[0];
        ill.op = 7'h7F;
        drive(ill);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ill7f_err", 32'(bus.err_illegal), 32'd1);
        chk("ill7f_cnt", 32'(bus.illegal_count), 32'd1);
        chk("ill7f_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("ill7f_err_drop", 32'(bus.err_illegal), 32'd0);
        ill.op = 7'h12;
        drive(ill);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ill12_err", 32'(bus.err_illegal), 32'd1);
        chk("ill12_cnt", 32'(bus.illegal_count), 32'd2);
        chk("ill12_valid", 32'(bus.out_valid), 32'd0);
        drive(ill);
        repeat (300) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ill_sat_cnt", 32'(bus.illegal_count), 32'd255);
        @(negedge clk);
        chk("ill_sat_hold", 32'(bus.illegal_count), 32'd255);

        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(tab[k + 1]);
            @(negedge clk);
            chk($sformatf("bp_in_ready%0d", k), 32'(bus.in_ready),
                32'(k < 3));
            chk("bp_word_stable", bus.out_word, tab[1].exp);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk($sformatf("drain_word%0d", k), bus.out_word,
                tab[k + 1].exp);
            chk($sformatf("drain_addr%0d", k), bus.out_addr,
                32'(4 * k));
            @(negedge clk);
        end
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
        ea = 32'd16;

        drive(tab[0]);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            chk("pp_valid", 32'(bus.out_valid), 32'd1);
            chk("pp_in_ready", 32'(bus.in_ready), 32'd1);
            chk($sformatf("pp_word%0d", k), bus.out_word,
                tab[k - 1].exp);
            chk("pp_addr", bus.out_addr, ea);
            ea = ea + 32'd4;
            drive(tab[k]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pp_last_word", bus.out_word, tab[5].exp);
        ea = ea + 32'd4;
        @(negedge clk);
        chk("pp_empty", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(tab[k]);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        drive(tab[4]);
        #1;
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("after_pop_ready", 32'(bus.in_ready), 32'd1);
        chk("after_pop_word", bus.out_word, tab[1].exp);
        chk("after_pop_addr", bus.out_addr, ea + 32'd4);

        rst_n = 1'b0;
        drive(tab[5]);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_addr", bus.out_addr, 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        drive(tab[0]);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mrst_next_word", bus.out_word, tab[0].exp);
        chk("mrst_next_addr", bus.out_addr, 32'd0);
        @(negedge clk);
        chk("mrst_next_empty", 32'(bus.out_valid), 32'd0);

        do_reset();
        q.delete();
        m_addr = '0;
        m_cnt  = '0;
        m_err  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            chk("rnd_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() < 4));
            if (q.size() != 0) begin
                chk("rnd_word", bus.out_word, q[0]);
                chk("rnd_addr", bus.out_addr, m_addr);
            end
            chk("rnd_err", 32'(bus.err_illegal), 32'(m_err));
            chk("rnd_cnt", 32'(bus.illegal_count), 32'(m_cnt));

            if ($urandom_range(0, 9) < 8)
                v.op = legal_ops[$urandom_range(0, 11)];
            else
                v.op = 7'($urandom);
            v.rd  = 5'($urandom);
            v.rs1 = 5'($urandom);
            v.rs2 = 5'($urandom);
            v.f3  = 3'($urandom);
            v.f7  = 7'($urandom);
            v.imm = $urandom;
            drive(v);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);

            model_enc(v, lg, w);
            acc = bus.in_valid && (q.size() < 4);
            pp  = (q.size() != 0) && bus.out_ready;
            if (pp) begin
                void'(q.pop_front());
                m_addr = m_addr + 32'd4;
            end
            if (acc && lg) q.push_back(w);
            m_err = acc && !lg;
            if (m_err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL: parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-002 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL: in_valid  input  1  field bundle valid.
REQ-005 SHALL: in_ready  output  1  bundle accepted when in_valid && in_ready.
REQ-006 SHALL: opcode  input  7  major opcode, with encoding format selected from opcode[6:2].
REQ-007 SHALL: rd, rs1, rs2  input  5 each  register indices.
REQ-008 SHALL: funct3  input  3; funct7  input  7.
REQ-009 SHALL: immediate_32bit  input  32  sign-carrying immediate in RISC-V value form (byte offset for B/J; upper value in [31:12] for U).
REQ-010 SHALL: out_valid  output  1; out_ready  input  1; out_word  output  32  encoded instruction; out_addr  output  32  byte address of out_word.
REQ-011 SHALL: err_illegal  output  1  one-cycle pulse when an accepted bundle is dropped as illegal; illegal_count  output  8  saturating count of dropped bundles.

Function
REQ-012 SHALL: format map on opcode[6:2]: R = 01100, 01110; I = 00100, 00000, 11001, 11100, 00110; S = 01000; B = 11000; U = 01101, 00101; J = 11011; any other value, or opcode[1:0] != 2'b11, is illegal.
REQ-013 SHALL: R encoding = {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-014 SHALL: I encoding = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-015 SHALL: S encoding = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-016 SHALL: B encoding = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; imm[0] is ignored.
REQ-017 SHALL: U encoding = {imm[31:12], rd, opcode}.
REQ-018 SHALL: J encoding = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; imm[0] is ignored.
REQ-019 SHALL: fields unused by a format are ignored, with no error.
REQ-020 SHALL: in_ready = !fifo_full, combinational from registered state only, with no path from out_ready.
REQ-021 SHALL: on accept of a legal bundle, the encoded word is written to the FIFO on that edge, and out_valid is high from the next cycle (latency 1).
REQ-022 SHALL: on accept of an illegal bundle, nothing is written, err_illegal pulses high the following cycle, and illegal_count increments, saturating at 255.
REQ-023 SHALL: out_valid = !fifo_empty; out_word/out_addr show the head entry and are held stable while out_valid && !out_ready.
REQ-024 SHALL: a pop occurs on out_valid && out_ready; out_addr starts at 0, advances by 4 per pop, and wraps modulo 2^32.
REQ-025 SHALL: a push and a pop in the same cycle are both performed, leaving occupancy unchanged; when full, in_ready is low even if a pop occurs that cycle.
REQ-026 SHALL: FIFO pointers wrap modulo FIFO_DEPTH, with full/empty distinguished by an occupancy counter of width clog2(FIFO_DEPTH)+1.

Reset
REQ-027 SHALL: while rst_n is low at a clock edge, the FIFO is emptied, the address counter is 0, illegal_count is 0, and err_illegal is 0.
REQ-028 SHALL: reset values are in_ready=1, out_valid=0, out_word=0, out_addr=0.
REQ-029 SHALL: a reset asserted mid-stream discards buffered words without emitting them, and an input handshake in that cycle is ignored.

Structure
REQ-030 SHALL: shared package miniRV_pkg holds the opcode[6:2] constants, an enum instr_format_t {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL}, and function fmt_of(opcode).
REQ-031 SHALL: buffering is one sub-module, instr_fifo (parameterised width/depth, push/pop/full/empty); encoding muxing stays in instr_encoder.

Verification
REQ-032 SHALL: opcode=0x13, rd=1, rs1=0, f3=0, imm=5 -> out_word=0x00500093, out_addr=0.
REQ-033 SHALL: R add x3,x1,x2 -> 0x002081B3; S sw x2,8(x1) (op 0x23, f3=2, imm=8) -> 0x0020A423; B beq x1,x2,+8 (op 0x63, imm=8) -> 0x00208463; outputs arrive in order with out_addr 0, 4, 8.
REQ-034 SHALL: U lui x5 (op 0x37, imm=0x12345000) -> 0x123452B7; J jal x1,+16 (op 0x6F, imm=16) -> 0x010000EF; imm=-4 on jal x0 -> 0xFFDFF06F.
REQ-035 SHALL: opcode 0x7F or 0x12 -> no output word, err_illegal pulses once, illegal_count=1; 300 illegal bundles -> illegal_count=255.
REQ-036 SHALL: out_ready=0 with 5 pushes -> in_ready low after the 4th push and out_word stable; releasing out_ready drains 4 words in order with out_addr 0..12; simultaneous push/pop keeps occupancy constant.
REQ-037 SHALL: rst_n low for 1 cycle with 3 words buffered -> out_valid=0 next cycle, out_addr=0, in_ready=1.
